// File: rtl/calculo_pkg.sv
// Shared constants for the calculation-unit wrapper: state encoding and default sizing.
package calculo_pkg;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 16;
    localparam int CW_DEF      = 5;

    typedef logic [2:0] estado_t;

    localparam estado_t ST_IDLE  = 3'd0;
    localparam estado_t ST_LOAD  = 3'd1;
    localparam estado_t ST_WAIT  = 3'd2;
    localparam estado_t ST_CLEAR = 3'd3;
    localparam estado_t ST_OUT   = 3'd4;

endpackage

// File: rtl/contador_timeout.sv
// Saturating up-counter of WAIT cycles; expira flags the cycle whose count+1 reaches TIMEOUT.
module contador_timeout #(
    parameter int CW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          expira
);

    logic [CW:0] siguiente;

    // One extra bit keeps count+1 exact even when count sits at the saturation value.
    assign siguiente = {1'b0, count} + 1'b1;
    assign expira    = (siguiente == (CW+1)'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CW'(TIMEOUT))) begin
            count <= siguiente[CW-1:0];
        end
    end

endmodule

// File: rtl/interface_calculo.sv
// Valid/ready wrapper around the calculation unit: launches it, waits for pronto with a
// watchdog, restarts the controller and hands the captured result back to the consumer.
//
//  state | meaning
//  IDLE  | ready for a new operand
//  LOAD  | operand on x_out, inicio pulsed
//  WAIT  | counting cycles until pronto or timeout
//  CLEAR | rst_ctrl pulsed to restart the controller
//  OUT   | result presented until res_ready
module interface_calculo
    import calculo_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_x,
    output logic [W-1:0]  x_out,
    output logic          inicio,
    input  logic          pronto,
    input  logic [W-1:0]  s_in,
    output logic          rst_ctrl,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          res_err,
    output logic [CW-1:0] ciclos,
    output logic          busy
);

    estado_t        estado;
    estado_t        prox;
    logic [CW-1:0]  count;
    logic           expira;
    logic           acepta;

    assign acepta = (estado == ST_IDLE) && req_valid;

    contador_timeout #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_contador (
        .clk    (clk),
        .rst    (rst),
        .clr    (acepta),
        .en     (estado == ST_WAIT),
        .count  (count),
        .expira (expira)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= ST_IDLE;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            ST_IDLE:  if (req_valid)          prox = ST_LOAD;
            ST_LOAD:                          prox = ST_WAIT;
            ST_WAIT:  if (pronto || expira)   prox = ST_CLEAR;
            ST_CLEAR:                         prox = ST_OUT;
            ST_OUT:   if (res_ready)          prox = ST_IDLE;
            default:                          prox = ST_IDLE;
        endcase
    end

    // Handshake and pulse outputs decode from state only, so no input reaches an output.
    always_comb begin
        req_ready = 1'b0;
        inicio    = 1'b0;
        rst_ctrl  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (estado)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD:  inicio    = 1'b1;
            ST_CLEAR: rst_ctrl  = 1'b1;
            ST_OUT:   res_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out    <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            ciclos   <= '0;
        end else begin
            if (acepta) begin
                x_out   <= req_x;
                res_err <= 1'b0;
            end
            // pronto is checked first so a same-cycle timeout never overrides a real result.
            if (estado == ST_WAIT) begin
                if (pronto) begin
                    res_data <= s_in;
                    ciclos   <= count + 1'b1;
                end else if (expira) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                    ciclos   <= CW'(TIMEOUT);
                end
            end
        end
    end

endmodule

// File: tb/tb_interface_calculo.sv
// Directed bench for interface_calculo with a cycle-timestamp reference model checked every cycle.
module tb_interface_calculo;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_x = '0;
    logic [W-1:0]  x_out;
    logic          inicio;
    logic          pronto = 1'b0;
    logic [W-1:0]  s_in = '0;
    logic          rst_ctrl;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          res_err;
    logic [CW-1:0] ciclos;
    logic          busy;

    interface_calculo #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .x_out     (x_out),
        .inicio    (inicio),
        .pronto    (pronto),
        .s_in      (s_in),
        .rst_ctrl  (rst_ctrl),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .ciclos    (ciclos),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int n_inicio = 0;
    int n_rstc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: one operation described by its accept edge and its completion edge.
    int           cyc = 0;
    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    int           t_acc = 0;
    int           t_done = 0;
    int           m_n;
    logic [W-1:0] m_x = '0;
    logic [W-1:0] m_data = '0;
    logic         m_err = 1'b0;
    int           m_cic = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_idle = 1'b1; m_done = 1'b0;
            m_x = '0; m_data = '0; m_err = 1'b0; m_cic = 0;
        end else if (m_idle) begin
            if (req_valid) begin
                m_idle = 1'b0; m_done = 1'b0; t_acc = cyc; m_x = req_x; m_err = 1'b0;
            end
        end else if (!m_done) begin
            if (cyc >= t_acc + 2) begin
                m_n = cyc - t_acc - 1;
                if (pronto) begin
                    m_data = s_in; m_err = 1'b0; m_cic = m_n; m_done = 1'b1; t_done = cyc;
                end else if (m_n == TIMEOUT) begin
                    m_data = '0; m_err = 1'b1; m_cic = TIMEOUT; m_done = 1'b1; t_done = cyc;
                end
            end
        end else if (cyc >= t_done + 2 && res_ready) begin
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (inicio === 1'b1) n_inicio++;
        if (rst_ctrl === 1'b1) n_rstc++;
        if (chk_en) begin
            chk("req_ready", req_ready, m_idle);
            chk("busy", busy, !m_idle);
            chk("inicio", inicio, !m_idle && !m_done && cyc == t_acc);
            chk("rst_ctrl", rst_ctrl, !m_idle && m_done && cyc == t_done);
            chk("res_valid", res_valid, !m_idle && m_done && cyc > t_done);
            chk("x_out", x_out, m_x);
            chk("res_data", res_data, m_data);
            chk("res_err", res_err, m_err);
            chk("ciclos", ciclos, m_cic);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [W-1:0] x);
        int n = 0;
        req_valid = 1'b1;
        req_x = x;
        while (req_ready !== 1'b1 && n < 60) begin tick(); n++; end
        chk("req_ready_wait", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("inicio_after_accept", inicio, 1);
        chk("x_out_accept", x_out, x);
    endtask

    // Controller stand-in: raise pronto d cycles after inicio (d=0: never) and hold it until restart.
    task automatic ctrl(input int d, input logic [W-1:0] s);
        int n = 0;
        if (d > 0) begin
            repeat (d) tick();
            pronto = 1'b1;
            s_in = s;
        end
        while (rst_ctrl !== 1'b1 && n < 40) begin tick(); n++; end
        chk("rst_ctrl_seen", rst_ctrl, 1);
        pronto = 1'b0;
        s_in = '0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (res_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("res_valid_seen", res_valid, 1);
    endtask

    int i0, r0;

    initial begin
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset held for three cycles in the middle of WAIT
        do_req(8'h33);
        tick(); tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_inicio", inicio, 0);
        chk("rst_rst_ctrl", rst_ctrl, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_x_out", x_out, 8'h00);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Stray pronto while idle
        pronto = 1'b1; tick(); pronto = 1'b0; tick();
        chk("stray_pronto_busy", busy, 0);

        // Nominal
        i0 = n_inicio; r0 = n_rstc;
        do_req(8'h2A);
        ctrl(8, 8'h91);
        wait_out();
        chk("nom_data", res_data, 8'h91);
        chk("nom_err", res_err, 0);
        chk("nom_ciclos", ciclos, 8);
        chk("nom_inicio_cnt", n_inicio - i0, 1);
        chk("nom_rstc_cnt", n_rstc - r0, 1);

        // Back-pressure with a competing request
        req_valid = 1'b1; req_x = 8'h77;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 8'h91);
            chk("bp_ciclos", ciclos, 8);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_x_out", x_out, 8'h2A);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        do_req(8'h77);
        ctrl(2, 8'h3C);
        wait_out();
        chk("bp2_data", res_data, 8'h3C);
        chk("bp2_ciclos", ciclos, 2);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // Timeout
        r0 = n_rstc;
        do_req(8'h55);
        ctrl(0, 8'h00);
        wait_out();
        chk("to_err", res_err, 1);
        chk("to_data", res_data, 8'h00);
        chk("to_ciclos", ciclos, 16);
        chk("to_rstc_cnt", n_rstc - r0, 1);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // pronto on the last WAIT cycle beats the timeout
        do_req(8'h66);
        ctrl(16, 8'h05);
        wait_out();
        chk("sim_err", res_err, 0);
        chk("sim_data", res_data, 8'h05);
        chk("sim_ciclos", ciclos, 16);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // Back-to-back with res_ready tied high
        res_ready = 1'b1;
        i0 = n_inicio; r0 = n_rstc;
        do_req(8'h01);
        ctrl(3, 8'hC3);
        wait_out();
        chk("b2b1_data", res_data, 8'hC3);
        chk("b2b1_ciclos", ciclos, 3);
        do_req(8'hFF);
        ctrl(5, 8'h5A);
        wait_out();
        chk("b2b2_data", res_data, 8'h5A);
        chk("b2b2_ciclos", ciclos, 5);
        tick();
        chk("b2b_inicio_cnt", n_inicio - i0, 2);
        chk("b2b_rstc_cnt", n_rstc - r0, 2);
        res_ready = 1'b0;

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/interface_calculo.md
Name: interface_calculo

Overview:
- Request/response wrapper around the calculation unit, which is the control FSM plus its datapath.
- Accepts an operand X on a valid/ready handshake and drives it to the datapath.
- Pulses `inicio` to the controller and waits for `pronto`.
- Captures the datapath result S, clears the controller with a one-cycle restart pulse, and presents the result on a valid/ready output handshake.
- Adds a watchdog so a stalled calculation never hangs the requester.

Parameters:
- W, 8, width of operand X and result S.
- TIMEOUT, 16, max WAIT cycles without `pronto` before aborting (must be ≥ 10).
- CW, 5, width of cycle counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  requester has operand.
- req_ready  out  1  block accepts operand.
- req_x  in  W  operand.
- x_out  out  W  registered operand driven to datapath X input.
- inicio  out  1  start pulse to controller.
- pronto  in  1  controller done (held high until controller restarted).
- s_in  in  W  datapath result register S.
- rst_ctrl  out  1  one-cycle restart pulse to controller.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  W  captured result.
- res_err  out  1  result aborted by timeout.
- ciclos  out  CW  WAIT cycles spent by the last operation.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at edge): state=IDLE. x_out, res_data, ciclos and the counter go to 0. inicio, rst_ctrl, res_valid and res_err go to 0. Reset has priority over every event, including mid-operation; any in-flight result is discarded.
- States: IDLE, LOAD, WAIT, CLEAR, OUT. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: x_out<=req_x, counter<=0, res_err<=0, go to LOAD.
  - Otherwise hold; x_out keeps its last value.
- LOAD:
  - inicio=1 for exactly this one cycle; x_out is stable. Go to WAIT.
  - inicio is never high in any other state.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT.
  - If pronto=1: res_data<=s_in, ciclos<=counter+1, go to CLEAR.
  - Else if counter+1==TIMEOUT: res_data<=0, res_err<=1, ciclos<=TIMEOUT, go to CLEAR.
  - If pronto and the timeout condition occur in the same cycle, pronto wins and res_err stays 0.
- CLEAR: rst_ctrl=1 for exactly one cycle, then go to OUT. rst_ctrl is issued on both the success and timeout paths.
- OUT:
  - res_valid=1; res_data, res_err and ciclos are held stable while waiting.
  - On res_ready=1: go to IDLE.
  - res_ready while not in OUT is ignored.
- Latency: request accept edge → inicio 1 cycle later. Pronto sample edge → res_valid 2 cycles later (CLEAR then OUT). Minimum back-to-back period is LOAD+WAIT+CLEAR+OUT+IDLE.
- req_valid may drop without acceptance; no operand is captured unless req_ready is high at the same edge.
- A pronto pulse outside WAIT is ignored.
- Counter width: CW bits unsigned. Comparison uses counter+1 without overflow because TIMEOUT < 2^CW.

Decomposition:
- Shared package `calculo_pkg`:
  - state encoding localparams (IDLE=0, LOAD=1, WAIT=2, CLEAR=3, OUT=4), 3-bit.
  - default W, TIMEOUT and CW constants.
- Sub-module `contador_timeout`:
  - inputs: clk, rst, clr, en.
  - outputs: count[CW], expira (count+1==TIMEOUT).
  - saturating counter.
  - Instantiated once; the FSM stays in the top module.

Test Plan:
- Reset: hold rst 3 cycles during WAIT → state IDLE, req_ready=1, inicio=0, rst_ctrl=0, res_valid=0, x_out=0.
- Nominal: req_x=8'h2A accepted. Model asserts pronto 8 cycles after inicio with s_in=8'h91 → inicio exactly 1 cycle, rst_ctrl 1 cycle, then res_valid=1, res_data=8'h91, res_err=0, ciclos=8.
- Back-pressure: res_ready=0 for 5 cycles in OUT → res_valid, res_data and ciclos stable. req_ready=0 and a new req_valid is not accepted until after res_ready.
- Timeout: pronto never asserted → after 16 WAIT cycles, res_err=1, res_data=0, ciclos=16, and rst_ctrl pulsed once.
- Simultaneous: pronto rises on the 16th WAIT cycle with s_in=8'h05 → res_err=0, res_data=8'h05, ciclos=16.
- Back-to-back: two requests (8'h01, 8'hFF) with res_ready tied high → each gets exactly one inicio and one rst_ctrl. Results come out in order, and x_out changes only on acceptance edges.
